multi_arbiter: RTL and testbench

Round-robin scheduler that shares one fixed-latency signed multiplier (`multi`: 32x32 signed, 64-bit product, start/valid handshake) among NREQ requesters. It accepts one request at a time and drives the multiplier's `start`, `mlier` and `mcand`. It returns the product to the granted requester and guards against a multiplier that never responds with a timeout. It sits between the requesting engines and the single `multi` instance.

---
 rtl/multi_arbiter.sv | 168 ++++++++++++++++
 tb/tb_multi_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_arbiter.sv
// Round-robin scheduler sharing one fixed-latency signed multiplier among NREQ requesters.
// States: IDLE grants/accepts, RUN waits for mul_valid or timeout, GAP holds start low one cycle.
module multi_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 40
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NREQ-1:0]    i_req_valid,
  output logic [NREQ-1:0]    o_req_ready,
  input  logic [NREQ*32-1:0] i_req_mlier,
  input  logic [NREQ*32-1:0] i_req_mcand,
  output logic [NREQ-1:0]    o_rsp_valid,
  output logic [63:0]        o_rsp_prodt,
  output logic               o_rsp_err,
  output logic               o_mul_start,
  output logic [31:0]        o_mul_mlier,
  output logic [31:0]        o_mul_mcand,
  input  logic [63:0]        i_mul_prodt,
  input  logic               i_mul_valid,
  output logic               o_busy,
  output logic               o_timeout_flag
);

  localparam int IW = $clog2(NREQ);
  localparam logic [IW-1:0] PTR_RST  = IW'(NREQ - 1);
  localparam logic [7:0]    CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_ptr, w_ptr_nxt;
  logic [IW-1:0]   r_gidx, w_gidx_nxt;
  logic [7:0]      r_cnt, w_cnt_nxt;
  logic            r_mul_start, w_mul_start_nxt;
  logic [31:0]     r_mul_mlier, w_mul_mlier_nxt;
  logic [31:0]     r_mul_mcand, w_mul_mcand_nxt;
  logic [NREQ-1:0] r_rsp_valid, w_rsp_valid_nxt;
  logic [63:0]     r_rsp_prodt, w_rsp_prodt_nxt;
  logic            r_rsp_err, w_rsp_err_nxt;
  logic            r_tflag, w_tflag_nxt;

  logic [NREQ-1:0] w_grant;
  logic [NREQ-1:0] w_gidx_oh;
  logic [IW-1:0]   w_gsel;
  logic [31:0]     w_sel_mlier;
  logic [31:0]     w_sel_mcand;
  logic            w_found;

  // Two-pass scan: indices above the pointer first, then wrap around to 0..pointer.
  always_comb begin
    w_grant     = '0;
    w_gsel      = '0;
    w_sel_mlier = '0;
    w_sel_mcand = '0;
    w_found     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && (i > int'(r_ptr)) && i_req_valid[i]) begin
        w_found     = 1'b1;
        w_gsel      = IW'(i);
        w_grant[i]  = 1'b1;
        w_sel_mlier = i_req_mlier[32*i +: 32];
        w_sel_mcand = i_req_mcand[32*i +: 32];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && (i <= int'(r_ptr)) && i_req_valid[i]) begin
        w_found     = 1'b1;
        w_gsel      = IW'(i);
        w_grant[i]  = 1'b1;
        w_sel_mlier = i_req_mlier[32*i +: 32];
        w_sel_mcand = i_req_mcand[32*i +: 32];
      end
    end
  end

  assign w_gidx_oh   = {{(NREQ-1){1'b0}}, 1'b1} << r_gidx;
  assign o_req_ready = ((r_state == S_IDLE) && !i_reset) ? w_grant : '0;

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_gidx_nxt      = r_gidx;
    w_cnt_nxt       = r_cnt;
    w_mul_start_nxt = r_mul_start;
    w_mul_mlier_nxt = r_mul_mlier;
    w_mul_mcand_nxt = r_mul_mcand;
    w_rsp_valid_nxt = '0;
    w_rsp_prodt_nxt = r_rsp_prodt;
    w_rsp_err_nxt   = 1'b0;
    w_tflag_nxt     = r_tflag;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_mul_mlier_nxt = w_sel_mlier;
          w_mul_mcand_nxt = w_sel_mcand;
          w_gidx_nxt      = w_gsel;
          w_ptr_nxt       = w_gsel;
          w_mul_start_nxt = 1'b1;
          w_cnt_nxt       = '0;
          w_state_nxt     = S_RUN;
        end
      end
      S_RUN: begin
        // A valid on the last permitted edge still counts as a normal completion.
        if (i_mul_valid) begin
          w_rsp_prodt_nxt = i_mul_prodt;
          w_rsp_valid_nxt = w_gidx_oh;
          w_mul_start_nxt = 1'b0;
          w_state_nxt     = S_GAP;
        end else if (r_cnt == CNT_LAST) begin
          w_rsp_prodt_nxt = '0;
          w_rsp_valid_nxt = w_gidx_oh;
          w_rsp_err_nxt   = 1'b1;
          w_tflag_nxt     = 1'b1;
          w_mul_start_nxt = 1'b0;
          w_state_nxt     = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_GAP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= PTR_RST;
      r_gidx      <= '0;
      r_cnt       <= '0;
      r_mul_start <= 1'b0;
      r_mul_mlier <= '0;
      r_mul_mcand <= '0;
      r_rsp_valid <= '0;
      r_rsp_prodt <= '0;
      r_rsp_err   <= 1'b0;
      r_tflag     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gidx      <= w_gidx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mul_start <= w_mul_start_nxt;
      r_mul_mlier <= w_mul_mlier_nxt;
      r_mul_mcand <= w_mul_mcand_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_prodt <= w_rsp_prodt_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_tflag     <= w_tflag_nxt;
    end
  end

  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_prodt    = r_rsp_prodt;
  assign o_rsp_err      = r_rsp_err;
  assign o_mul_start    = r_mul_start;
  assign o_mul_mlier    = r_mul_mlier;
  assign o_mul_mcand    = r_mul_mcand;
  assign o_busy         = (r_state != S_IDLE);
  assign o_timeout_flag = r_tflag;

endmodule

// File: tb/tb_multi_arbiter.sv
// Randomized scoreboard bench for multi_arbiter with a latency-programmable multiplier model.
module tb_multi_arbiter;
  localparam int NREQ = 4;
  localparam int TMO  = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NREQ-1:0]    req_valid, req_ready, rsp_valid;
  logic [NREQ*32-1:0] req_mlier, req_mcand;
  logic [63:0]        rsp_prodt, mul_prodt;
  logic               rsp_err, mul_start, mul_valid, busy, timeout_flag;
  logic [31:0]        mul_mlier, mul_mcand;
  logic [31:0]        opa [NREQ];
  logic [31:0]        opb [NREQ];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          idx;
    logic [63:0] prodt;
    bit          err;
    int          cyc;
  } rsp_t;

  rsp_t sbq[$];
  int   acc_log[$];
  int   acc_cyc[$];
  logic [NREQ-1:0] acc_seen = '0;

  // reference model state
  int          mptr = NREQ - 1;
  bit          have = 1'b0;
  int          acc_k = 0, n_exp = 0;
  bit          exp_err = 1'b0;
  bit          tflag_m = 1'b0;
  logic [31:0] cur_a, cur_b;
  logic [63:0] cur_prod, last_prodt = '0;
  int          lat = 35;
  int          lat_cur = 35;
  int          mc = 0;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_mlier[32*g +: 32] = opa[g];
    assign req_mcand[32*g +: 32] = opb[g];
  end

  multi_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_mlier(req_mlier), .i_req_mcand(req_mcand),
    .o_rsp_valid(rsp_valid), .o_rsp_prodt(rsp_prodt), .o_rsp_err(rsp_err),
    .o_mul_start(mul_start), .o_mul_mlier(mul_mlier), .o_mul_mcand(mul_mcand),
    .i_mul_prodt(mul_prodt), .i_mul_valid(mul_valid),
    .o_busy(busy), .o_timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    int r = -1;
    for (int d = 1; d <= NREQ; d++) begin
      if (r < 0 && v[(p + d) % NREQ]) r = (p + d) % NREQ;
    end
    return r;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  // Multiplier model: valid is sampled high on the lat_cur-th edge after acceptance.
  always @(negedge clk) begin
    if (rst || !mul_start) begin
      mc = 0;
      mul_valid = 1'b0;
      mul_prodt = {$urandom, $urandom};
    end else begin
      mc++;
      if (mc >= lat_cur) begin
        mul_valid = 1'b1;
        mul_prodt = longint'($signed(mul_mlier)) * longint'($signed(mul_mcand));
      end else begin
        mul_prodt = {$urandom, $urandom};
      end
    end
  end

  // Reference model: predicts grants, busy/start windows, sticky flag; pushes responses.
  always @(negedge clk) begin : trk
    logic [NREQ-1:0] exp_ready;
    bit idle, exp_start, exp_busy;
    int g;
    rsp_t e;
    if (rst) begin
      mptr = NREQ - 1;
      have = 1'b0;
      sbq.delete();
      last_prodt = '0;
      tflag_m = 1'b0;
      acc_seen = '0;
    end else begin
      if (have && cyc == acc_k + n_exp) begin
        last_prodt = exp_err ? 64'd0 : cur_prod;
        if (exp_err) tflag_m = 1'b1;
      end
      idle      = !have || (cyc > acc_k + n_exp);
      exp_start = have && (cyc < acc_k + n_exp);
      exp_busy  = have && (cyc <= acc_k + n_exp);
      g         = idle ? rr_pick(req_valid, mptr) : -1;
      exp_ready = oh(g);
      chk("req_ready", req_ready, exp_ready);
      chk("busy", busy, exp_busy);
      chk("mul_start", mul_start, exp_start);
      chk("timeout_flag", timeout_flag, tflag_m);
      if (exp_start) begin
        chk("mul_mlier", mul_mlier, cur_a);
        chk("mul_mcand", mul_mcand, cur_b);
      end
      if (rsp_valid == '0) chk("rsp_prodt_hold", rsp_prodt, last_prodt);
      if (g >= 0) begin
        acc_log.push_back(g);
        acc_cyc.push_back(cyc + 1);
        acc_seen[g] = 1'b1;
        mptr     = g;
        have     = 1'b1;
        acc_k    = cyc + 1;
        lat_cur  = lat;
        exp_err  = (lat > TMO);
        n_exp    = exp_err ? TMO : lat;
        cur_a    = opa[g];
        cur_b    = opb[g];
        cur_prod = longint'($signed(opa[g])) * longint'($signed(opb[g]));
        e.idx    = g;
        e.prodt  = exp_err ? 64'd0 : cur_prod;
        e.err    = exp_err;
        e.cyc    = acc_k + n_exp;
        sbq.push_back(e);
      end
    end
  end

  // Monitor: pops the scoreboard whenever a response is due or presented.
  always @(negedge clk) begin : mon
    rsp_t e;
    bit due;
    if (!rst) begin
      due = 1'b0;
      if (sbq.size() > 0) due = (sbq[0].cyc == cyc);
      if (due || rsp_valid != '0 || rsp_err) begin
        chk("rsp_due", 64'(due), 64'd1);
        chk("rsp_present", 64'(rsp_valid != '0), 64'd1);
        if (due) begin
          e = sbq.pop_front();
          chk("rsp_target", rsp_valid, oh(e.idx));
          chk("rsp_prodt", rsp_prodt, e.prodt);
          chk("rsp_err", rsp_err, e.err);
        end
      end
    end
  end

  task automatic drive(input int nacc, input logic [NREQ-1:0] hold);
    int done = 0;
    int t = 0;
    int budget = nacc * (TMO + 6) + 20;
    while (done < nacc && t < budget) begin
      @(posedge clk); #1;
      t++;
      if (acc_seen != '0) begin
        for (int i = 0; i < NREQ; i++) begin
          if (acc_seen[i]) begin
            done++;
            opa[i] = $urandom;
            opb[i] = $urandom;
            if (!hold[i]) req_valid[i] = 1'b0;
          end
        end
        acc_seen = '0;
      end
    end
    chk("accept_count", done, nacc);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy !== 1'b0 || sbq.size() != 0) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("idle_reached", 64'(busy === 1'b0 && sbq.size() == 0), 64'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, '0);
    chk({tag, "_rsp_valid"}, rsp_valid, '0);
    chk({tag, "_rsp_prodt"}, rsp_prodt, '0);
    chk({tag, "_rsp_err"}, rsp_err, '0);
    chk({tag, "_mul_start"}, mul_start, '0);
    chk({tag, "_mul_mlier"}, mul_mlier, '0);
    chk({tag, "_mul_mcand"}, mul_mcand, '0);
    chk({tag, "_busy"}, busy, '0);
    chk({tag, "_timeout_flag"}, timeout_flag, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic op1(input int r, input logic [31:0] a, input logic [31:0] b,
                     input longint want, input string nm);
    opa[r] = a;
    opb[r] = b;
    req_valid[r] = 1'b1;
    drive(1, '0);
    wait_idle();
    chk(nm, rsp_prodt, want);
  endtask

  int fair_exp [6] = '{0, 2, 0, 2, 0, 2};

  initial begin
    req_valid = '1;
    mul_valid = 1'b0;
    mul_prodt = '0;
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = $urandom;
      opb[i] = $urandom;
    end
    #1 rst = 1'b1;
    #1 chk_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    req_valid = '0;
    rst = 1'b0;

    lat = 35;
    op1(0, 32'd147483646, 32'd1, 147483646, "single_prodt");
    op1(0, -32'sd10, -32'sd12345, 123450, "signed_a");
    op1(0, 32'd147483646, -32'sd1, -64'sd147483646, "signed_b");
    op1(0, -32'sd147483646, -32'sd1, 147483646, "signed_c");
    chk("no_timeout_yet", timeout_flag, 1'b0);

    do_reset();
    acc_log.delete();
    acc_cyc.delete();
    req_valid = '1;
    drive(4, '0);
    wait_idle();
    chk("simul_n", acc_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < acc_log.size()) chk("simul_order", acc_log[i], i);
      if (i > 0 && i < acc_cyc.size()) chk("simul_spacing", acc_cyc[i] - acc_cyc[i-1], 37);
    end

    acc_log.delete();
    req_valid = 4'b0101;
    drive(6, 4'b0101);
    req_valid = '0;
    wait_idle();
    chk("fair_n", acc_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < acc_log.size()) chk("fair_order", acc_log[i], fair_exp[i]);
    end

    lat = 1000;
    op1(1, 32'd77, 32'd99, 0, "timeout_prodt");
    chk("timeout_flag_set", timeout_flag, 1'b1);
    lat = 35;
    op1(3, 32'd7, -32'sd3, -21, "after_timeout_prodt");
    chk("timeout_flag_sticky", timeout_flag, 1'b1);
    lat = 40;
    op1(2, 32'd5, 32'd6, 30, "edge40_prodt");
    lat = 41;
    op1(0, 32'd5, 32'd6, 0, "edge41_prodt");

    do_reset();
    lat = 35;
    acc_log.delete();
    req_valid = 4'b0100;
    drive(1, '0);
    repeat (10) @(posedge clk);
    #1;
    req_valid = 4'b0110;
    rst = 1'b1;
    #1 chk_zero("midrun");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    acc_log.delete();
    drive(2, '0);
    wait_idle();
    chk("post_reset_n", acc_log.size(), 2);
    if (acc_log.size() == 2) begin
      chk("post_reset_first", acc_log[0], 1);
      chk("post_reset_second", acc_log[1], 2);
    end

    for (int it = 0; it < 40; it++) begin
      int r;
      logic [NREQ-1:0] m;
      r = $urandom_range(0, 9);
      lat = (r == 0) ? 1000 : (r == 1) ? 40 : (r == 2) ? 41 : $urandom_range(1, 45);
      m = req_valid | NREQ'($urandom_range(1, 15));
      if ((m & ~NREQ'($urandom_range(0, 15))) != '0) m = m & ~NREQ'($urandom_range(0, 15));
      if (m == '0) m = 4'b0001;
      req_valid = m;
      drive(1, NREQ'($urandom_range(0, 15)));
    end
    req_valid = '0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
